// File: rtl/shift_tx_ctrl_pkg.sv
// Shared constants for the serial word transmitter: default word width and
// the controller state encoding.
package shift_tx_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_reg_load.sv
// WIDTH-bit right shift register with parallel load, shift enable,
// zero serial fill and asynchronous active-low clear.
module shift_reg_load
  import shift_tx_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load wins over shift so an accepted word is never disturbed on its first edge.
  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_tx_ctrl.sv
// Serial word transmitter: accepts a parallel word, shifts it out LSB first
// with a pause input, then pulses done for one cycle before returning to idle.
module shift_tx_ctrl
  import shift_tx_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             sdo,
  output logic             sdo_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             accept;
  logic             shift_en;
  logic             last_bit;

  // Handshake: a word transfers on the posedge where din_valid and din_ready
  // are both 1; din_ready is high only in IDLE, and nothing is buffered while busy.
  assign accept   = (state == ST_IDLE) && din_valid;
  assign shift_en = (state == ST_SHIFT) && !hold;
  assign last_bit = shift_en && (cnt == '0);

  shift_reg_load #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clk      (clk),
    .clrb     (clrb),
    .load     (accept),
    .shift_en (shift_en),
    .d        (din),
    .q        (sreg)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (din_valid) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit)  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The counter saturates at zero; leaving SHIFT is decided by last_bit.
  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CW'(WIDTH - 1);
      end else if (shift_en && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign din_ready = (state == ST_IDLE);
  assign busy      = (state == ST_SHIFT) || (state == ST_DONE);
  assign done      = (state == ST_DONE);
  assign sdo_en    = (state == ST_SHIFT) && !hold;
  assign sdo       = (state == ST_SHIFT) ? sreg[0] : 1'b0;
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Bench for shift_tx_ctrl: directed word scenarios with literal expectations
// plus randomized traffic compared every cycle against a word-level model.
module tb_shift_tx_ctrl;

  localparam int WIDTH = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             clrb = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             hold = 1'b0;
  logic             din_ready;
  logic             sdo;
  logic             sdo_en;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  shift_tx_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .clrb      (clrb),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .hold      (hold),
    .sdo       (sdo),
    .sdo_en    (sdo_en),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, state_dbg=%0d)",
               name, act, exp, cyc, state_dbg);
    end
  endtask

  // ---------------- word-level reference model ----------------
  // A word is either being sent (m_sent bits already out) or finished (m_done).
  logic             m_active = 1'b0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_word = '0;
  int               m_sent = 0;

  always @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_word   = '0;
      m_sent   = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (!hold) begin
        m_sent = m_sent + 1;
        if (m_sent == WIDTH) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (din_valid) begin
      m_active = 1'b1;
      m_word   = din;
      m_sent   = 0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("din_ready", din_ready, !m_active && !m_done);
    chk("busy",      busy,      m_active || m_done);
    chk("done",      done,      m_done);
    chk("sdo_en",    sdo_en,    m_active && !hold);
    chk("sdo",       sdo,       m_active ? m_word[m_sent] : 1'b0);
  end

  // ---------------- driver tasks ----------------
  logic [3:0] log_q[$];
  logic [3:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs n cycles after a handshake cycle, logging {done, sdo_en, sdo, din_ready}.
  task automatic capture(input int n, input logic [15:0] hmask, input bit scramble,
                         input logic [WIDTH-1:0] dnext, input bit keep);
    log_q.delete();
    for (int i = 0; i < n; i++) begin
      step();
      hold = hmask[i];
      if (scramble) begin
        din       = WIDTH'($urandom);
        din_valid = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        din = dnext;
        if (!keep) din_valid = 1'b0;
      end
      @(negedge clk);
      log_q.push_back({done, sdo_en, sdo, din_ready});
    end
    hold = 1'b0;
  endtask

  task automatic compare_log(input string name);
    chk({name, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s[%0d]", name, i), log_q[i], exp_q[i]);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_sdo"},       sdo,       1'b0);
    chk({tag, "_sdo_en"},    sdo_en,    1'b0);
    chk({tag, "_busy"},      busy,      1'b0);
    chk({tag, "_done"},      done,      1'b0);
    chk({tag, "_din_ready"}, din_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    chk_reset_values("rst_async");
    #10 clrb = 1'b1;
    step();
    step();
    chk_reset_values("rst_released");

    // Plain word, no hold
    din = 4'b1011; din_valid = 1'b1;
    capture(6, 16'h0000, 1'b0, 4'b1011, 1'b0);
    exp_q = '{4'b0110, 4'b0110, 4'b0100, 4'b0110, 4'b1000, 4'b0001};
    compare_log("word_1011");

    // Same word with hold in cycles N+2..N+3
    din = 4'b1011; din_valid = 1'b1;
    capture(8, 16'h0006, 1'b0, 4'b1011, 1'b0);
    exp_q = '{4'b0110, 4'b0010, 4'b0010, 4'b0110, 4'b0100, 4'b0110, 4'b1000, 4'b0001};
    compare_log("word_hold");

    // din_valid held high: back-to-back words every WIDTH+2 cycles
    din = 4'b0110; din_valid = 1'b1;
    capture(12, 16'h0000, 1'b0, 4'b1001, 1'b1);
    din_valid = 1'b0;
    exp_q = '{4'b0100, 4'b0110, 4'b0110, 4'b0100, 4'b1000, 4'b0001,
              4'b0110, 4'b0100, 4'b0100, 4'b0110, 4'b1000, 4'b0001};
    compare_log("back_to_back");
    repeat (8) step();

    // Inputs scrambled while busy must not disturb the word in flight
    din = 4'b1011; din_valid = 1'b1;
    capture(6, 16'h0000, 1'b1, 4'b0000, 1'b0);
    exp_q = '{4'b0110, 4'b0110, 4'b0100, 4'b0110, 4'b1000, 4'b0001};
    compare_log("busy_ignore");

    // Reset during bit 2 of 4'b1111 aborts silently
    din = 4'b1111; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    #2 clrb = 1'b0;
    #1;
    chk_reset_values("rst_mid_word");
    @(negedge clk);
    #2 clrb = 1'b1;
    capture(3, 16'h0000, 1'b0, 4'b0000, 1'b0);
    exp_q = '{4'b0001, 4'b0001, 4'b0001};
    compare_log("after_abort");
    din = 4'b0001; din_valid = 1'b1;
    capture(6, 16'h0000, 1'b0, 4'b0001, 1'b0);
    exp_q = '{4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    compare_log("word_0001");

    // Randomized traffic, checked by the per-cycle scoreboard
    repeat (400) begin
      step();
      din       = WIDTH'($urandom);
      din_valid = ($urandom_range(0, 2) != 0);
      hold      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 clrb = 1'b0;
        #4 clrb = 1'b1;
      end
    end
    din_valid = 1'b0;
    hold      = 1'b0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
